// File: rtl/cache_set_assoc.sv
// N-way set-associative tag/valid model with true-LRU replacement and
// saturating hit/miss statistics; one lookup per cycle, registered response.
module cache_set_assoc #(
   parameter int ADDR_W      = 11,
   parameter int OFFSET_BITS = 2,
   parameter int INDEX_BITS  = 3,
   parameter int WAYS        = 2,
   parameter int CNT_W       = 16,
   localparam int TAG_W      = ADDR_W - INDEX_BITS - OFFSET_BITS,
   localparam int WAY_W      = (WAYS > 1) ? $clog2(WAYS) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   input  logic [ADDR_W-1:0] addr,
   input  logic              flush,
   output logic              resp_valid,
   output logic              hit,
   output logic [WAY_W-1:0]  hit_way,
   output logic              evict,
   output logic [TAG_W-1:0]  evict_tag,
   output logic [CNT_W-1:0]  hit_count,
   output logic [CNT_W-1:0]  miss_count
);

   localparam int SETS = 1 << INDEX_BITS;
   localparam logic [WAY_W-1:0] OLDEST = WAY_W'(WAYS - 1);

   logic [TAG_W-1:0] tag_q   [SETS][WAYS];
   logic [TAG_W-1:0] tag_d   [SETS][WAYS];
   logic [WAY_W-1:0] age_q   [SETS][WAYS];
   logic [WAY_W-1:0] age_d   [SETS][WAYS];
   logic [WAYS-1:0]  valid_q [SETS];
   logic [WAYS-1:0]  valid_d [SETS];

   logic             resp_valid_q, resp_valid_d;
   logic             hit_q, hit_d;
   logic [WAY_W-1:0] hit_way_q, hit_way_d;
   logic             evict_q, evict_d;
   logic [TAG_W-1:0] evict_tag_q, evict_tag_d;
   logic [CNT_W-1:0] hit_count_q, hit_count_d;
   logic [CNT_W-1:0] miss_count_q, miss_count_d;

   logic [INDEX_BITS-1:0] set_idx;
   logic [TAG_W-1:0]      req_tag;
   logic [WAYS-1:0]       way_match;
   logic                  lookup_hit;
   logic [WAY_W-1:0]      match_idx;
   logic [WAY_W-1:0]      victim_idx;
   logic [WAY_W-1:0]      access_way;
   logic [WAY_W-1:0]      old_age;
   logic                  match_found;
   logic                  invalid_found;

   assign set_idx = addr[OFFSET_BITS +: INDEX_BITS];
   assign req_tag = addr[ADDR_W-1 -: TAG_W];

   genvar gi;
   generate
      for (gi = 0; gi < WAYS; gi++) begin : g_match
         assign way_match[gi] = valid_q[set_idx][gi] && (tag_q[set_idx][gi] == req_tag);
      end
   endgenerate

   assign lookup_hit = |way_match;

   // Lowest matching way wins; victim is the lowest invalid way, else the LRU way.
   always_comb begin
      match_idx     = '0;
      match_found   = 1'b0;
      victim_idx    = '0;
      invalid_found = 1'b0;
      for (int w = 0; w < WAYS; w++) begin
         if (way_match[w] && !match_found) begin
            match_idx   = WAY_W'(w);
            match_found = 1'b1;
         end
         if (!valid_q[set_idx][w] && !invalid_found) begin
            victim_idx    = WAY_W'(w);
            invalid_found = 1'b1;
         end
      end
      if (!invalid_found) begin
         for (int w = 0; w < WAYS; w++) begin
            if (age_q[set_idx][w] == OLDEST) begin
               victim_idx = WAY_W'(w);
            end
         end
      end
      access_way = lookup_hit ? match_idx : victim_idx;
      old_age    = age_q[set_idx][access_way];
   end

   always_comb begin
      tag_d        = tag_q;
      age_d        = age_q;
      valid_d      = valid_q;
      resp_valid_d = 1'b0;
      hit_d        = hit_q;
      hit_way_d    = hit_way_q;
      evict_d      = evict_q;
      evict_tag_d  = evict_tag_q;
      hit_count_d  = hit_count_q;
      miss_count_d = miss_count_q;

      if (flush) begin
         for (int s = 0; s < SETS; s++) begin
            valid_d[s] = '0;
            for (int w = 0; w < WAYS; w++) begin
               age_d[s][w] = WAY_W'(w);
            end
         end
         hit_count_d  = '0;
         miss_count_d = '0;
      end else if (req_valid) begin
         resp_valid_d = 1'b1;
         hit_d        = lookup_hit;
         hit_way_d    = access_way;
         evict_d      = !lookup_hit && valid_q[set_idx][victim_idx];
         evict_tag_d  = (!lookup_hit && valid_q[set_idx][victim_idx])
                        ? tag_q[set_idx][victim_idx] : '0;
         if (!lookup_hit) begin
            valid_d[set_idx][victim_idx] = 1'b1;
            tag_d[set_idx][victim_idx]   = req_tag;
         end
         // Touched way becomes MRU; only ways younger than it age by one.
         for (int w = 0; w < WAYS; w++) begin
            if (WAY_W'(w) == access_way) begin
               age_d[set_idx][w] = '0;
            end else if (age_q[set_idx][w] < old_age) begin
               age_d[set_idx][w] = age_q[set_idx][w] + WAY_W'(1);
            end
         end
         if (lookup_hit) begin
            if (hit_count_q != {CNT_W{1'b1}}) begin
               hit_count_d = hit_count_q + CNT_W'(1);
            end
         end else begin
            if (miss_count_q != {CNT_W{1'b1}}) begin
               miss_count_d = miss_count_q + CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < SETS; s++) begin
            valid_q[s] <= '0;
            for (int w = 0; w < WAYS; w++) begin
               tag_q[s][w] <= '0;
               age_q[s][w] <= WAY_W'(w);
            end
         end
         resp_valid_q <= 1'b0;
         hit_q        <= 1'b0;
         hit_way_q    <= '0;
         evict_q      <= 1'b0;
         evict_tag_q  <= '0;
         hit_count_q  <= '0;
         miss_count_q <= '0;
      end else begin
         tag_q        <= tag_d;
         age_q        <= age_d;
         valid_q      <= valid_d;
         resp_valid_q <= resp_valid_d;
         hit_q        <= hit_d;
         hit_way_q    <= hit_way_d;
         evict_q      <= evict_d;
         evict_tag_q  <= evict_tag_d;
         hit_count_q  <= hit_count_d;
         miss_count_q <= miss_count_d;
      end
   end

   assign resp_valid = resp_valid_q;
   assign hit        = hit_q;
   assign hit_way    = hit_way_q;
   assign evict      = evict_q;
   assign evict_tag  = evict_tag_q;
   assign hit_count  = hit_count_q;
   assign miss_count = miss_count_q;

endmodule

// File: tb/tb_cache_set_assoc.sv
// Bench for cache_set_assoc: three builds (default, CNT_W=4, WAYS=4) driven
// from a vector table and a saturation loop, checked through a scoreboard queue.
module tb_cache_set_assoc;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          dut;
      logic        rst;
      logic        req;
      logic        flush;
      logic [10:0] addr;
      logic        rv;
      logic        hit;
      logic [1:0]  way;
      logic        ev;
      logic [5:0]  etag;
      logic [15:0] hc;
      logic [15:0] mc;
   } vec_t;

   int total = 0;
   int bad   = 0;
   vec_t exp_q[$];
   vec_t tbl[$];

   logic        rst_v   [3];
   logic        req_v   [3];
   logic        flush_v [3];
   logic [10:0] addr_v  [3];

   logic       rv_a, hit_a, ev_a;
   logic [0:0] way_a;
   logic [5:0] etag_a;
   logic [15:0] hc_a, mc_a;

   logic       rv_b, hit_b, ev_b;
   logic [0:0] way_b;
   logic [5:0] etag_b;
   logic [3:0] hc_b, mc_b;

   logic       rv_c, hit_c, ev_c;
   logic [1:0] way_c;
   logic [5:0] etag_c;
   logic [15:0] hc_c, mc_c;

   cache_set_assoc dut_a (
      .clk(clk), .rst(rst_v[0]), .req_valid(req_v[0]), .addr(addr_v[0]), .flush(flush_v[0]),
      .resp_valid(rv_a), .hit(hit_a), .hit_way(way_a), .evict(ev_a), .evict_tag(etag_a),
      .hit_count(hc_a), .miss_count(mc_a));

   cache_set_assoc #(.CNT_W(4)) dut_b (
      .clk(clk), .rst(rst_v[1]), .req_valid(req_v[1]), .addr(addr_v[1]), .flush(flush_v[1]),
      .resp_valid(rv_b), .hit(hit_b), .hit_way(way_b), .evict(ev_b), .evict_tag(etag_b),
      .hit_count(hc_b), .miss_count(mc_b));

   cache_set_assoc #(.WAYS(4)) dut_c (
      .clk(clk), .rst(rst_v[2]), .req_valid(req_v[2]), .addr(addr_v[2]), .flush(flush_v[2]),
      .resp_valid(rv_c), .hit(hit_c), .hit_way(way_c), .evict(ev_c), .evict_tag(etag_c),
      .hit_count(hc_c), .miss_count(mc_c));

   function automatic vec_t mk(int dut, bit rst, bit req, bit flush, int addr,
                               bit rv, bit hit, int way, bit ev, int etag, int hc, int mc);
      vec_t v;
      v.dut = dut;  v.rst = rst;  v.req = req;  v.flush = flush;  v.addr = 11'(addr);
      v.rv = rv;  v.hit = hit;  v.way = 2'(way);  v.ev = ev;  v.etag = 6'(etag);
      v.hc = 16'(hc);  v.mc = 16'(mc);
      return v;
   endfunction

   function automatic vec_t observe(int d);
      vec_t a;
      a = mk(d, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      case (d)
         0: begin a.rv = rv_a; a.hit = hit_a; a.way = {1'b0, way_a}; a.ev = ev_a;
                  a.etag = etag_a; a.hc = hc_a; a.mc = mc_a; end
         1: begin a.rv = rv_b; a.hit = hit_b; a.way = {1'b0, way_b}; a.ev = ev_b;
                  a.etag = etag_b; a.hc = {12'd0, hc_b}; a.mc = {12'd0, mc_b}; end
         default: begin a.rv = rv_c; a.hit = hit_c; a.way = way_c; a.ev = ev_c;
                  a.etag = etag_c; a.hc = hc_c; a.mc = mc_c; end
      endcase
      return a;
   endfunction

   task automatic chk(string name, int idx, int dut, logic [15:0] act, logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s dut=%0d step=%0d got=%0d expected=%0d", name, dut, idx, act, exp);
      end
   endtask

   task automatic apply(vec_t v, int idx);
      vec_t e;
      vec_t a;
      @(negedge clk);
      rst_v[v.dut]   = v.rst;
      req_v[v.dut]   = v.req;
      flush_v[v.dut] = v.flush;
      addr_v[v.dut]  = v.addr;
      exp_q.push_back(v);
      @(posedge clk);
      #1;
      rst_v[v.dut]   = 1'b0;
      req_v[v.dut]   = 1'b0;
      flush_v[v.dut] = 1'b0;
      e = exp_q.pop_front();
      a = observe(e.dut);
      chk("resp_valid", idx, e.dut, 16'(a.rv),   16'(e.rv));
      chk("hit",        idx, e.dut, 16'(a.hit),  16'(e.hit));
      chk("hit_way",    idx, e.dut, 16'(a.way),  16'(e.way));
      chk("evict",      idx, e.dut, 16'(a.ev),   16'(e.ev));
      chk("evict_tag",  idx, e.dut, 16'(a.etag), 16'(e.etag));
      chk("hit_count",  idx, e.dut, a.hc, e.hc);
      chk("miss_count", idx, e.dut, a.mc, e.mc);
      $display("step %0d dut=%0d rst=%0b req=%0b flush=%0b addr=%0d -> rv=%0b hit=%0b way=%0d ev=%0b etag=%0d hc=%0d mc=%0d",
               idx, e.dut, e.rst, e.req, e.flush, e.addr, a.rv, a.hit, a.way, a.ev, a.etag, a.hc, a.mc);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      for (int d = 0; d < 3; d++) begin
         rst_v[d] = 1'b0; req_v[d] = 1'b0; flush_v[d] = 1'b0; addr_v[d] = '0;
      end

      //          dut rst req fl addr  rv hit way ev etag hc mc
      tbl.push_back(mk(0, 1, 0, 0,    0,  0, 0, 0, 0,  0, 0, 0));
      tbl.push_back(mk(0, 0, 1, 0,   34,  1, 0, 0, 0,  0, 0, 1));
      tbl.push_back(mk(0, 0, 1, 0,   34,  1, 1, 0, 0,  0, 1, 1));
      tbl.push_back(mk(0, 0, 1, 0,  512,  1, 0, 1, 0,  0, 1, 2));
      tbl.push_back(mk(0, 0, 1, 0,   34,  1, 1, 0, 0,  0, 2, 2));
      tbl.push_back(mk(0, 0, 1, 0,  768,  1, 0, 1, 1, 16, 2, 3));
      tbl.push_back(mk(0, 0, 1, 0,  512,  1, 0, 0, 1,  1, 2, 4));
      tbl.push_back(mk(0, 0, 1, 0,  200,  1, 0, 0, 0,  0, 2, 5));
      tbl.push_back(mk(0, 0, 1, 0,  528,  1, 0, 0, 0,  0, 2, 6));
      tbl.push_back(mk(0, 0, 1, 0,  200,  1, 1, 0, 0,  0, 3, 6));
      tbl.push_back(mk(0, 0, 1, 0,  528,  1, 1, 0, 0,  0, 4, 6));
      tbl.push_back(mk(0, 0, 1, 0,  512,  1, 1, 0, 0,  0, 5, 6));
      tbl.push_back(mk(0, 0, 1, 0,  768,  1, 1, 1, 0,  0, 6, 6));
      tbl.push_back(mk(0, 0, 0, 0,    0,  0, 1, 1, 0,  0, 6, 6));
      tbl.push_back(mk(0, 0, 1, 1,   34,  0, 1, 1, 0,  0, 0, 0));
      tbl.push_back(mk(0, 0, 1, 0,   34,  1, 0, 0, 0,  0, 0, 1));
      tbl.push_back(mk(0, 0, 1, 0,   35,  1, 1, 0, 0,  0, 1, 1));
      tbl.push_back(mk(0, 1, 1, 0,   34,  0, 0, 0, 0,  0, 0, 0));
      tbl.push_back(mk(0, 0, 1, 0,   34,  1, 0, 0, 0,  0, 0, 1));
      tbl.push_back(mk(2, 1, 0, 0,    0,  0, 0, 0, 0,  0, 0, 0));
      tbl.push_back(mk(2, 0, 1, 0,   34,  1, 0, 0, 0,  0, 0, 1));
      tbl.push_back(mk(2, 0, 1, 0,  512,  1, 0, 1, 0,  0, 0, 2));
      tbl.push_back(mk(2, 0, 1, 0,  768,  1, 0, 2, 0,  0, 0, 3));
      tbl.push_back(mk(2, 0, 1, 0, 1024,  1, 0, 3, 0,  0, 0, 4));
      tbl.push_back(mk(2, 0, 1, 0, 1280,  1, 0, 0, 1,  1, 0, 5));
      tbl.push_back(mk(2, 0, 1, 0,   34,  1, 0, 1, 1, 16, 0, 6));
      tbl.push_back(mk(2, 0, 1, 0, 1280,  1, 1, 0, 0,  0, 1, 6));

      for (int i = 0; i < tbl.size(); i++) begin
         apply(tbl[i], i);
      end

      // Counter saturation on the CNT_W=4 build.
      apply(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 100);
      apply(mk(1, 0, 1, 0, 34, 1, 0, 0, 0, 0, 0, 1), 101);
      for (int i = 1; i <= 20; i++) begin
         apply(mk(1, 0, 1, 0, 34, 1, 1, 0, 0, 0, (i > 15) ? 15 : i, 1), 101 + i);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
